// File: rtl/dcm_pkg.sv
// Shared definitions for the DCM lock supervisor: FSM state encoding and
// the STATUS bit that flags a stopped CLKFX.
package dcm_pkg;

    typedef enum logic [2:0] {
        RESET_DCM = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAILED    = 3'd4
    } dcm_state_t;

    localparam int ST_CLKFX_STOPPED = 2;

endpackage

// File: rtl/dcm_sync2.sv
// Two-flop synchroniser for slow asynchronous levels; both stages clear to 0
// on reset so downstream logic sees "not locked" until real samples arrive.
module dcm_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/dcm_supervisor.sv
// Lock supervisor / reset sequencer for a clock-synthesis DCM. Runs on CLKIN,
// pulses DCM reset on loss of lock or stopped CLKFX, and gates system reset.
module dcm_supervisor
    import dcm_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 3,
    parameter int LOCK_TIMEOUT_CYC = 120000,
    parameter int SETTLE_CYC       = 256,
    parameter int MAX_RETRIES      = 15,
    parameter int CNT_W            = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dcm_locked,
    input  logic [7:0] dcm_status,
    input  logic       clr_fail,
    output logic       dcm_rst,
    output logic       sys_rst_n,
    output logic       clk_ok,
    output logic [3:0] retry_cnt,
    output logic       fail
);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    logic [1:0] sync_in;
    logic [1:0] sync_out;
    logic       locked_s;
    logic       fxstop_s;
    logic       good;

    assign sync_in = {dcm_status[ST_CLKFX_STOPPED], dcm_locked};

    dcm_sync2 #(
        .WIDTH(2)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sync_in),
        .q    (sync_out)
    );

    assign locked_s = sync_out[0];
    assign fxstop_s = sync_out[1];
    assign good     = locked_s & ~fxstop_s;

    dcm_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       retry_reg, retry_next;
    logic             dcm_rst_reg, sys_rst_n_reg, clk_ok_reg, fail_reg;
    logic             give_up;

    // A failed acquisition either retries or, once the budget is spent, parks in FAILED.
    assign give_up = (retry_reg == RETRY_MAX);

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;

        unique case (state_reg)
            RESET_DCM: begin
                if (cnt_reg == PULSE_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (good) begin
                    state_next = SETTLE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = give_up ? FAILED : RESET_DCM;
                    retry_next = give_up ? retry_reg : retry_reg + 4'd1;
                end
            end
            SETTLE: begin
                if (!good) begin
                    state_next = give_up ? FAILED : RESET_DCM;
                    retry_next = give_up ? retry_reg : retry_reg + 4'd1;
                end else if (cnt_reg == SETTLE_LAST) begin
                    state_next = RUN;
                    retry_next = '0;
                end
            end
            RUN: begin
                if (!good) state_next = RESET_DCM;
            end
            FAILED: begin
                if (clr_fail) begin
                    state_next = RESET_DCM;
                    retry_next = '0;
                end
            end
            default: begin
                state_next = RESET_DCM;
            end
        endcase
    end

    // Timer restarts on every state change; it only needs to run in the timed states.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (state_reg == RESET_DCM || state_reg == WAIT_LOCK || state_reg == SETTLE) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RESET_DCM;
            cnt_reg       <= '0;
            retry_reg     <= '0;
            dcm_rst_reg   <= 1'b1;
            sys_rst_n_reg <= 1'b0;
            clk_ok_reg    <= 1'b0;
            fail_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            retry_reg     <= retry_next;
            // Outputs decode next-state so they move on the same edge as the state.
            dcm_rst_reg   <= (state_next == RESET_DCM) || (state_next == FAILED);
            sys_rst_n_reg <= (state_next == RUN);
            clk_ok_reg    <= (state_next == RUN);
            fail_reg      <= (state_next == FAILED);
        end
    end

    assign dcm_rst   = dcm_rst_reg;
    assign sys_rst_n = sys_rst_n_reg;
    assign clk_ok    = clk_ok_reg;
    assign retry_cnt = retry_reg;
    assign fail      = fail_reg;

endmodule

// File: tb/tb_dcm_supervisor.sv
// Scoreboard bench for dcm_supervisor: a phase/duration reference model predicts
// the outputs after every CLK edge; a monitor compares them one edge later.
module tb_dcm_supervisor;

    localparam int P_PULSE   = 3;
    localparam int P_TIMEOUT = 50;
    localparam int P_SETTLE  = 8;
    localparam int P_MAXR    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_req = 1'b0;
    logic       dcm_locked = 1'b0;
    logic [7:0] dcm_status = 8'h00;
    logic       clr_fail = 1'b0;
    logic       dcm_rst, sys_rst_n, clk_ok, fail;
    logic [3:0] retry_cnt;

    dcm_supervisor #(
        .RST_PULSE_CYC   (P_PULSE),
        .LOCK_TIMEOUT_CYC(P_TIMEOUT),
        .SETTLE_CYC      (P_SETTLE),
        .MAX_RETRIES     (P_MAXR),
        .CNT_W           (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dcm_locked(dcm_locked),
        .dcm_status(dcm_status),
        .clr_fail  (clr_fail),
        .dcm_rst   (dcm_rst),
        .sys_rst_n (sys_rst_n),
        .clk_ok    (clk_ok),
        .retry_cnt (retry_cnt),
        .fail      (fail)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       dcm_rst;
        logic       sys_rst_n;
        logic       clk_ok;
        logic       fail;
        logic [3:0] retry;
    } obs_t;

    localparam obs_t RESET_OBS = '{dcm_rst: 1'b1, sys_rst_n: 1'b0, clk_ok: 1'b0, fail: 1'b0, retry: 4'd0};

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: which phase we are in, how many edges spent there, retries used,
    // and the two-edge visibility delay of the asynchronous inputs.
    typedef enum int {M_PULSE, M_WAIT, M_SETTLE, M_RUN, M_FAIL} mphase_t;
    mphase_t m_phase = M_PULSE;
    int      m_elapsed = 0;
    int      m_retries = 0;
    bit      lk_meta = 0, lk_seen = 0, fx_meta = 0, fx_seen = 0;

    task automatic model_reset();
        m_phase = M_PULSE; m_elapsed = 0; m_retries = 0;
        lk_meta = 0; lk_seen = 0; fx_meta = 0; fx_seen = 0;
    endtask

    task automatic enter(input mphase_t p);
        m_phase = p; m_elapsed = 0;
    endtask

    task automatic acquisition_failed();
        if (m_retries == P_MAXR) enter(M_FAIL);
        else begin
            m_retries = m_retries + 1;
            enter(M_PULSE);
        end
    endtask

    task automatic model_edge();
        bit good;
        if (!rst_n) begin
            model_reset();
            return;
        end
        good = lk_seen && !fx_seen;
        m_elapsed = m_elapsed + 1;
        case (m_phase)
            M_PULSE:  if (m_elapsed == P_PULSE) enter(M_WAIT);
            M_WAIT:   if (good) enter(M_SETTLE);
                      else if (m_elapsed == P_TIMEOUT) acquisition_failed();
            M_SETTLE: if (!good) acquisition_failed();
                      else if (m_elapsed == P_SETTLE) begin m_retries = 0; enter(M_RUN); end
            M_RUN:    if (!good) enter(M_PULSE);
            M_FAIL:   if (clr_fail) begin m_retries = 0; enter(M_PULSE); end
            default:  enter(M_PULSE);
        endcase
        lk_seen = lk_meta; lk_meta = dcm_locked;
        fx_seen = fx_meta; fx_meta = dcm_status[2];
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.dcm_rst   = (m_phase == M_PULSE) || (m_phase == M_FAIL);
        o.sys_rst_n = (m_phase == M_RUN);
        o.clk_ok    = (m_phase == M_RUN);
        o.fail      = (m_phase == M_FAIL);
        o.retry     = 4'(m_retries);
        return o;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the prediction for the next rise.
    task automatic step(input logic lk, input logic [7:0] st, input logic clr);
        @(negedge clk);
        rst_n = rst_req;
        dcm_locked = lk; dcm_status = st; clr_fail = clr;
        model_edge();
        exp_q.push_back(model_obs());
    endtask

    task automatic idle(input int n, input logic lk, input logic [7:0] st);
        for (int i = 0; i < n; i++) step(lk, st, 1'b0);
    endtask

    task automatic run_until(input mphase_t ph, input int el, input logic lk, input int budget, input string tag);
        int n = 0;
        while (!(m_phase == ph && m_elapsed == el) && n < budget) begin
            step(lk, 8'h00, 1'b0);
            n++;
        end
        if (n >= budget) begin
            checks++; failures++;
            $display("FAIL %s: model phase %0d not reached within %0d cycles", tag, ph, budget);
        end
    endtask

    task automatic async_reset_check(input string tag);
        obs_t a;
        @(posedge clk);
        #3;
        rst_req = 1'b0;
        rst_n = 1'b0;
        #1;
        a = {dcm_rst, sys_rst_n, clk_ok, fail, retry_cnt};
        checks++;
        if (a !== RESET_OBS) begin
            failures++;
            $display("FAIL %s: got %b want %b (dcm_rst,sys_rst_n,clk_ok,fail,retry)", tag, a, RESET_OBS);
        end
        model_reset();
        idle(3, dcm_locked, 8'h00);
        rst_req = 1'b1;
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {dcm_rst, sys_rst_n, clk_ok, fail, retry_cnt};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs @%0t: got dcm_rst=%b sys_rst_n=%b clk_ok=%b fail=%b retry=%0d, want dcm_rst=%b sys_rst_n=%b clk_ok=%b fail=%b retry=%0d",
                             $time, a.dcm_rst, a.sys_rst_n, a.clk_ok, a.fail, a.retry,
                             e.dcm_rst, e.sys_rst_n, e.clk_ok, e.fail, e.retry);
                end
            end
        end
    end

    initial begin : driver
        bit   found;
        bit   lk, fx;
        logic [7:0] st;

        // Scenario 1: reset, then lock 20 cycles after release; RUN exactly 11 edges later.
        idle(4, 1'b0, 8'h00);
        rst_req = 1'b1;
        idle(20, 1'b0, 8'h00);
        step(1'b1, 8'h00, 1'b0);
        found = 0;
        for (int k = 1; k <= 40 && !found; k++) begin
            step(1'b1, 8'h00, 1'b0);
            if (sys_rst_n === 1'b1) begin
                found = 1;
                checks++;
                if (k != 11) begin
                    failures++;
                    $display("FAIL lock_to_run: sys_rst_n rose after %0d edges, want 11", k);
                end
            end
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL lock_to_run: sys_rst_n never rose within 40 edges, want 11");
        end
        idle(5, 1'b1, 8'h00);

        // Scenario 4: unused STATUS bits toggle harmlessly, then CLKFX stop forces a DCM reset.
        for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom) & 8'h83, 1'b0);
        idle(4, 1'b1, 8'h04);
        idle(20, 1'b1, 8'h00);

        // Scenario 3: loss of lock in RUN, then re-lock.
        idle(4, 1'b0, 8'h00);
        idle(25, 1'b1, 8'h00);

        // Scenario 5: lock glitch after 4 settle cycles.
        idle(2, 1'b0, 8'h00);
        run_until(M_SETTLE, 4, 1'b1, 40, "reach_settle");
        idle(2, 1'b0, 8'h00);
        idle(30, 1'b1, 8'h00);

        // Scenario 2: lock never arrives -> retries exhausted -> FAILED, then clear.
        idle(180, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1);
        idle(20, 1'b0, 8'h00);

        // Scenario 6: asynchronous reset in SETTLE and in FAILED.
        idle(40, 1'b0, 8'h00);
        run_until(M_SETTLE, 3, 1'b1, 120, "reach_settle_for_reset");
        async_reset_check("async_reset_settle");
        idle(5, 1'b0, 8'h00);
        run_until(M_FAIL, 2, 1'b0, 250, "reach_failed");
        async_reset_check("async_reset_failed");
        idle(10, 1'b0, 8'h00);

        // Randomised soak: slowly wandering lock/stop levels, noisy unused bits, sporadic clears.
        lk = 1; fx = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) lk = !lk;
            if ($urandom_range(0, 59) == 0) fx = !fx;
            st = (8'($urandom) & 8'hFB) | (fx ? 8'h04 : 8'h00);
            step(lk, st, ($urandom_range(0, 29) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcm_supervisor.md
Name: dcm_supervisor

Overview:
- Lock supervisor and reset sequencer placed directly downstream of the clock-synthesis DCM.
- Consumes the DCM's LOCKED and STATUS outputs and drives the DCM's RST input.
- On loss of lock or a stopped CLKFX, it pulses DCM reset and retries, bounded by a timeout and a retry limit.
- Releases system reset to CLKFX-domain logic only after lock has been held stably. Runs on the reference input clock, so it keeps working while CLKFX is dead.

Parameters:
- RST_PULSE_CYC, 3: CLK cycles DCM_RST is held high per attempt (DCM minimum is 3 CLKIN cycles).
- LOCK_TIMEOUT_CYC, 120000: CLK cycles allowed in WAIT_LOCK before a retry (5 ms at 24 MHz).
- SETTLE_CYC, 256: consecutive locked cycles required before SYS_RST_N is released.
- MAX_RETRIES, 15: retries allowed before declaring failure.
- CNT_W, 17: timer width; must hold LOCK_TIMEOUT_CYC-1.

Ports:
- CLK  in  1  reference clock (same net as DCM CLKIN).
- RST_N  in  1  asynchronous, active-low reset.
- DCM_LOCKED  in  1  DCM LOCKED; asynchronous to CLK.
- DCM_STATUS  in  8  DCM STATUS; only bit 2 (CLKFX stopped) is used; asynchronous.
- CLR_FAIL  in  1  synchronous level; leaves FAILED.
- DCM_RST  out  1  to DCM RST, active high.
- SYS_RST_N  out  1  active-low reset to CLKFX-domain logic; consumers synchronise its deassertion.
- CLK_OK  out  1  high only in RUN.
- RETRY_CNT  out  4  retries in the current acquisition.
- FAIL  out  1  high only in FAILED.

Behaviour:
- Input synchronisation:
  - DCM_LOCKED and DCM_STATUS[2] pass through a 2-flop synchroniser, giving locked_s and fxstop_s.
  - good = locked_s & ~fxstop_s.
- Timer: one CNT_W-bit counter, cleared on every state change.
- Outputs are registered and decoded from next-state, so they change on the same edge as the state register.
- Async reset values: state RESET_DCM, cnt 0, DCM_RST 1, SYS_RST_N 0, CLK_OK 0, RETRY_CNT 0, FAIL 0, sync flops 0.
- RESET_DCM:
  - DCM_RST=1, SYS_RST_N=0.
  - Go to WAIT_LOCK at the edge where cnt==RST_PULSE_CYC-1, giving exactly RST_PULSE_CYC cycles high.
- WAIT_LOCK:
  - DCM_RST=0, SYS_RST_N=0.
  - If good: go to SETTLE.
  - Else if cnt==LOCK_TIMEOUT_CYC-1: if RETRY_CNT==MAX_RETRIES go to FAILED, otherwise RETRY_CNT+1 and go to RESET_DCM.
  - If both good and the timeout fire on the same cycle, good wins.
- SETTLE:
  - DCM_RST=0, SYS_RST_N=0.
  - If ~good: same retry/fail rule as a timeout.
  - Else at cnt==SETTLE_CYC-1: go to RUN and clear RETRY_CNT.
- RUN:
  - SYS_RST_N=1, CLK_OK=1.
  - If ~good: go to RESET_DCM. SYS_RST_N and CLK_OK drop on that edge; RETRY_CNT is not incremented.
  - Worst-case latency from an input deassert to SYS_RST_N low is 3 CLK edges.
- FAILED:
  - DCM_RST=1, SYS_RST_N=0, FAIL=1.
  - CLR_FAIL=1: clear RETRY_CNT and go to RESET_DCM.
- RETRY_CNT saturates logically at MAX_RETRIES; it never wraps.
- An RST_N assertion in any state returns immediately to the reset values. The DCM is reset again on release.
- DCM_STATUS bits other than 2 are ignored.

Decomposition:
- Shared package dcm_pkg holds:
  - state encoding constants: RESET_DCM, WAIT_LOCK, SETTLE, RUN, FAILED;
  - the STATUS bit index constant ST_CLKFX_STOPPED=2.
- One sub-module, dcm_sync2: a parameterised-width 2-flop synchroniser with async active-low reset to 0. It is instantiated once with width 2.

Test Plan:
All scenarios use RST_PULSE_CYC=3, LOCK_TIMEOUT_CYC=50, SETTLE_CYC=8, MAX_RETRIES=2.
1. Reset and normal lock:
   - Stimulus: release RST_N; raise DCM_LOCKED 20 cycles later.
   - Response: DCM_RST high for exactly the first 3 cycles; SYS_RST_N and CLK_OK rise exactly 11 edges after DCM_LOCKED rises; RETRY_CNT=0.
2. Lock never arrives:
   - Stimulus: DCM_LOCKED held 0.
   - Response: DCM_RST pulses of 3 cycles at cycles 0, 53 and 106; RETRY_CNT steps 1, 2; FAIL=1 and DCM_RST=1 from cycle 159.
   - Follow-up: CLR_FAIL for 1 cycle gives RETRY_CNT=0 and a new 3-cycle pulse sequence.
3. Loss in RUN:
   - Stimulus: drop DCM_LOCKED while in RUN.
   - Response: SYS_RST_N low within 3 edges; DCM_RST high 3 cycles; RETRY_CNT stays 0; re-lock returns to RUN.
4. CLKFX stop:
   - Stimulus: DCM_STATUS[2]=1 with LOCKED=1 while in RUN.
   - Response: same as scenario 3. Bits 0, 1 and 7 toggling alone produce no change.
5. Lock glitch in SETTLE:
   - Stimulus: LOCKED drops after 4 settle cycles.
   - Response: RETRY_CNT=1, DCM reset issued, SYS_RST_N never rises during the glitch.
6. Reset mid-operation:
   - Stimulus: assert RST_N in SETTLE and in FAILED.
   - Response: all outputs immediately at their reset values, asynchronously, without waiting for a CLK edge.
